// File: rtl/imem_boot_loader.sv
// imem_boot_loader: byte-stream loader filling instruction memory, then
// releasing the core. Optional trailing XOR checksum via `CHECKSUM_EN.
//
// Ports:
//   clk, rst (async, active-low)
//   byte_valid/byte_data/byte_ready : inbound byte link
//   imem_we/imem_addr/imem_wdata    : instruction-memory write port
//   core_rst (active-low), done, error : load status
module imem_boot_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DATA,
`ifdef CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

`ifdef CHECKSUM_EN
    localparam state_t S_FINAL = S_CHK;
`else
    localparam state_t S_FINAL = S_DONE;
`endif

    state_t      state;
    state_t      state_d;
    logic        take;
    logic [15:0] count_q;
    logic [15:0] hdr_count;
    logic [15:0] word_idx;
    logic [1:0]  lane;
    logic [23:0] part;
    logic        last_word;
`ifdef CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign take      = byte_valid & byte_ready;
    assign hdr_count = {byte_data, count_q[7:0]};
    assign last_word = (word_idx + 16'd1) == count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_HDR0;
        else      state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_HDR0: if (take) state_d = S_HDR1;
            S_HDR1: begin
                if (take) begin
                    if (hdr_count == 16'd0)
                        state_d = S_FINAL;
                    else if ({1'b0, hdr_count} > DEPTH_L)
                        state_d = S_ERR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (take && lane == 2'd3 && last_word)
                    state_d = S_FINAL;
            end
`ifdef CHECKSUM_EN
            S_CHK: begin
                if (take)
                    state_d = (byte_data == csum) ? S_DONE : S_ERR;
            end
`endif
            S_DONE: state_d = S_DONE;
            S_ERR:  state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= 32'd0;
            core_rst   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            count_q    <= 16'd0;
            word_idx   <= 16'd0;
            lane       <= 2'd0;
            part       <= 24'd0;
`ifdef CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            byte_ready <= (state_d != S_DONE) && (state_d != S_ERR);
            imem_we    <= 1'b0;
            // done/core_rst lag DONE entry by a cycle so the final
            // write strobe is always retired before the core fetches.
            done       <= (state == S_DONE);
            core_rst   <= (state == S_DONE);
            error      <= (state_d == S_ERR);
            if (take && state == S_HDR0)
                count_q[7:0] <= byte_data;
            if (take && state == S_HDR1)
                count_q[15:8] <= byte_data;
            if (take && state == S_DATA) begin
                lane <= lane + 2'd1;
`ifdef CHECKSUM_EN
                csum <= csum ^ byte_data;
`endif
                unique case (lane)
                    2'd0: part[7:0]   <= byte_data;
                    2'd1: part[15:8]  <= byte_data;
                    2'd2: part[23:16] <= byte_data;
                    2'd3: begin
                        imem_we    <= 1'b1;
                        imem_wdata <= {byte_data, part};
                        imem_addr  <= BASE_ADDR
                                    + {14'd0, word_idx, 2'b00};
                        word_idx   <= word_idx + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: randomized stream bench for imem_boot_loader
// against a queue-based image model.
module tb_imem_boot_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        error;

    imem_boot_loader #(
        .BASE_ADDR(BASE),
        .DEPTH_WORDS(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .byte_ready(byte_ready),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst(core_rst),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    int vecs = 0;
    int errs = 0;
    int cyc = 0;

    wr_t         got[$];
    int          prev_we_cyc;
    int          done_cyc;
    int          min_space;
    logic [31:0] exp_words[$];
    logic [7:0]  stream[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we) begin
            got.push_back('{a: imem_addr, d: imem_wdata});
            if (prev_we_cyc >= 0 && cyc - prev_we_cyc < min_space)
                min_space = cyc - prev_we_cyc;
            prev_we_cyc = cyc;
        end
        if (done && done_cyc < 0) done_cyc = cyc;
    end

    task automatic clear_mon();
        got.delete();
        prev_we_cyc = -1;
        done_cyc = -1;
        min_space = 1000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        byte_valid = 1'b0;
        repeat (4) @(negedge clk);
        clear_mon();
        rst = 1'b1;
    endtask

    // Image model: header then LSB-first payload, optional XOR trailer.
    task automatic build_stream(input int hdr);
        logic [7:0] c;
        c = 8'h00;
        stream.delete();
        stream.push_back(8'(hdr));
        stream.push_back(8'(hdr >> 8));
        foreach (exp_words[i]) begin
            for (int k = 0; k < 4; k++) begin
                stream.push_back(8'(exp_words[i] >> (8 * k)));
                c = c ^ 8'(exp_words[i] >> (8 * k));
            end
        end
`ifdef CHECKSUM_EN
        stream.push_back(c);
`endif
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int w;
        w = 0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data = b;
        while (!byte_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        vecs++;
        if (byte_ready !== 1'b1) begin
            errs++;
            $display("FAIL send_ready got %b req 1", byte_ready);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data = 8'($urandom);
    endtask

    task automatic run_and_check(input string nm, input int max_gap);
        int w;
        foreach (stream[i])
            send(stream[i], max_gap > 0 ? $urandom_range(0, max_gap) : 0);
        w = 0;
        while (!(done || error) && w < 20) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        vecs++;
        if (got.size() != exp_words.size()) begin
            errs++;
            $display("FAIL %s n_writes got %0d req %0d",
                     nm, got.size(), exp_words.size());
        end
        foreach (got[i]) begin
            if (i < exp_words.size()) begin
                vecs++;
                if (got[i].a !== BASE + 32'(4 * i) ||
                    got[i].d !== exp_words[i]) begin
                    errs++;
                    $display("FAIL %s wr%0d got %h:%h req %h:%h", nm, i,
                             got[i].a, got[i].d,
                             BASE + 32'(4 * i), exp_words[i]);
                end
            end
        end
        vecs++;
        if ({done, core_rst, error, byte_ready} !== 4'b1100) begin
            errs++;
            $display("FAIL %s status d/c/e/r got %b req 1100", nm,
                     {done, core_rst, error, byte_ready});
        end
`ifndef CHECKSUM_EN
        if (exp_words.size() > 0) begin
            vecs++;
            if (done_cyc != prev_we_cyc + 1) begin
                errs++;
                $display("FAIL %s done_lag got %0d req 1",
                         nm, done_cyc - prev_we_cyc);
            end
        end
`endif
        if (exp_words.size() > 1) begin
            vecs++;
            if (max_gap == 0 ? min_space != 4 : min_space < 4) begin
                errs++;
                $display("FAIL %s we_spacing got %0d req %s4", nm,
                         min_space, max_gap == 0 ? "" : ">=");
            end
        end
    endtask

    task automatic load_t1();
        exp_words.delete();
        exp_words.push_back(32'h0010_0513);
        exp_words.push_back(32'h0020_0593);
        build_stream(2);
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        clear_mon();
        vecs++;
        if ({byte_ready, imem_we, core_rst, done, error} !== 5'b0 ||
            imem_addr !== BASE || imem_wdata !== 32'd0) begin
            errs++;
            $display("FAIL reset_vals got %b %h %h req 00000 %h 0",
                     {byte_ready, imem_we, core_rst, done, error},
                     imem_addr, imem_wdata, BASE);
        end
        rst = 1'b1;
        @(negedge clk);
        vecs++;
        if (byte_ready !== 1'b1) begin
            errs++;
            $display("FAIL ready_after_rel got %b req 1", byte_ready);
        end
    endtask

    task automatic test_basic();
        do_reset();
        load_t1();
        run_and_check("t1", 0);
    endtask

    task automatic test_zero();
        do_reset();
        exp_words.delete();
        build_stream(0);
        run_and_check("zero", 0);
    endtask

    task automatic test_overflow(input int hdr);
        int bad;
        do_reset();
        exp_words.delete();
        build_stream(hdr);
        send(stream[0], 0);
        send(stream[1], 0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            byte_valid = 1'($urandom);
            byte_data = 8'($urandom);
            @(negedge clk);
            if (error !== 1'b1 || byte_ready !== 1'b0 ||
                core_rst !== 1'b0 || done !== 1'b0)
                bad++;
        end
        byte_valid = 1'b0;
        vecs++;
        if (bad != 0 || got.size() != 0) begin
            errs++;
            $display("FAIL overflow_%0d bad_cycles %0d writes %0d req 0 0",
                     hdr, bad, got.size());
        end
    endtask

    task automatic test_max_depth();
        do_reset();
        exp_words.delete();
        for (int i = 0; i < DEPTH; i++) exp_words.push_back($urandom);
        build_stream(DEPTH);
        run_and_check("depth_max", 0);
    endtask

    task automatic test_gaps();
        for (int r = 0; r < 3; r++) begin
            do_reset();
            load_t1();
            run_and_check("t1_gaps", 5);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        load_t1();
        for (int i = 0; i < 6; i++) send(stream[i], 0);
        rst = 1'b0;
        #1;
        vecs++;
        if ({byte_ready, imem_we, core_rst, done, error} !== 5'b0 ||
            imem_addr !== BASE || imem_wdata !== 32'd0) begin
            errs++;
            $display("FAIL async_rst got %b %h %h req 00000 %h 0",
                     {byte_ready, imem_we, core_rst, done, error},
                     imem_addr, imem_wdata, BASE);
        end
        do_reset();
        run_and_check("t5_rerun", 0);
    endtask

    task automatic test_after_done();
        int n;
        do_reset();
        load_t1();
        run_and_check("t1_pre", 0);
        n = got.size();
        for (int i = 0; i < 24; i++) begin
            byte_valid = 1'b1;
            byte_data = 8'($urandom);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        vecs++;
        if (got.size() != n || done !== 1'b1 || core_rst !== 1'b1) begin
            errs++;
            $display("FAIL after_done writes %0d done %b req %0d 1",
                     got.size(), done, n);
        end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 10; it++) begin
            do_reset();
            n = $urandom_range(0, 6);
            exp_words.delete();
            for (int i = 0; i < n; i++) exp_words.push_back($urandom);
            build_stream(n);
            run_and_check("random", it % 2 == 0 ? 0 : 3);
        end
    endtask

`ifdef CHECKSUM_EN
    task automatic test_bad_checksum();
        do_reset();
        load_t1();
        stream[stream.size() - 1] = stream[stream.size() - 1] ^ 8'h01;
        foreach (stream[i]) send(stream[i], 0);
        repeat (3) @(negedge clk);
        vecs++;
        if ({done, core_rst, error, byte_ready} !== 4'b0010) begin
            errs++;
            $display("FAIL bad_csum d/c/e/r got %b req 0010",
                     {done, core_rst, error, byte_ready});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_overflow(DEPTH + 1);
        test_overflow(16'h0100);
        test_max_depth();
        test_gaps();
        test_reset_mid();
        test_after_done();
        test_random();
`ifdef CHECKSUM_EN
        test_bad_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout global");
        $fatal(1, "timeout");
    end

endmodule
